// File: rtl/array_multiplier_sequencer.sv
// Iterative unsigned multiplier: one array-multiplier stage reused for
// DATA_WIDTH/PRODUCT_PER_STAGE cycles, with valid/ready on both sides.
`timescale 1ns/1ps

module array_multiplier_sequencer #(
    parameter int DATA_WIDTH        = 8,
    parameter int PRODUCT_PER_STAGE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clear_i,
    input  logic [DATA_WIDTH-1:0]   operand_A_i,
    input  logic [DATA_WIDTH-1:0]   operand_B_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [2*DATA_WIDTH-1:0] product_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o
);
    localparam int ITERATIONS = DATA_WIDTH / PRODUCT_PER_STAGE;
    localparam int CNT_W      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

    generate
        if (DATA_WIDTH < 2 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a power of 2 and at least 2");
        end
        if (PRODUCT_PER_STAGE < 1 || (PRODUCT_PER_STAGE & (PRODUCT_PER_STAGE - 1)) != 0) begin : g_bad_pps
            $error("PRODUCT_PER_STAGE must be a power of 2");
        end
        if (PRODUCT_PER_STAGE > DATA_WIDTH || (DATA_WIDTH % PRODUCT_PER_STAGE) != 0) begin : g_bad_div
            $error("PRODUCT_PER_STAGE must divide DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [DATA_WIDTH-1:0]    a_reg;
    logic [DATA_WIDTH-1:0]    b_reg;
    logic [DATA_WIDTH-2:0]    pp_reg;
    logic                     carry_reg;
    logic [DATA_WIDTH-1:0]    lo_reg;
    logic [CNT_W-1:0]         cnt_reg;

    logic [DATA_WIDTH-2:0]        stage_pp;
    logic                         stage_carry;
    logic [PRODUCT_PER_STAGE-1:0] stage_bits;
    logic [DATA_WIDTH-1:0]        lo_shifted;
    logic                         accept;

    pipelined_array_multiplier_stage #(
        .DATA_WIDTH        (DATA_WIDTH),
        .PRODUCT_PER_STAGE (PRODUCT_PER_STAGE)
    ) u_stage (
        .operand_A_i         (a_reg),
        .operand_B_i         (b_reg[PRODUCT_PER_STAGE-1:0]),
        .last_partial_prod_i (pp_reg),
        .carry_i             (carry_reg),
        .partial_product_o   (stage_pp),
        .carry_o             (stage_carry),
        .final_result_bits_o (stage_bits)
    );

    // Low product bits enter at the MSB end so the first chunk ends up at bit 0.
    generate
        if (PRODUCT_PER_STAGE == DATA_WIDTH) begin : g_lo_full
            assign lo_shifted = stage_bits;
        end else begin : g_lo_shift
            assign lo_shifted = {stage_bits, lo_reg[DATA_WIDTH-1:PRODUCT_PER_STAGE]};
        end
    endgenerate

    assign ready_o   = (state_reg == IDLE);
    assign busy_o    = (state_reg == COMPUTE);
    assign valid_o   = (state_reg == DONE);
    assign product_o = {carry_reg, pp_reg, lo_reg};
    assign accept    = (state_reg == IDLE) && valid_i && !clear_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_i) state_next = COMPUTE;
            COMPUTE: if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE:    if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_reg     <= '0;
            b_reg     <= '0;
            pp_reg    <= '0;
            carry_reg <= 1'b0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
        end else if (clear_i) begin
            cnt_reg <= '0;
        end else if (accept) begin
            a_reg     <= operand_A_i;
            b_reg     <= operand_B_i;
            pp_reg    <= '0;
            carry_reg <= 1'b0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
        end else if (state_reg == COMPUTE) begin
            pp_reg    <= stage_pp;
            carry_reg <= stage_carry;
            lo_reg    <= lo_shifted;
            b_reg     <= b_reg >> PRODUCT_PER_STAGE;
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end
endmodule

// One array-multiplier slice: adds A * B_chunk to the running upper half
// {carry_i, last_partial_prod_i}; the low PRODUCT_PER_STAGE bits retire.
module pipelined_array_multiplier_stage #(
    parameter int DATA_WIDTH        = 8,
    parameter int PRODUCT_PER_STAGE = 4
) (
    input  logic [DATA_WIDTH-1:0]        operand_A_i,
    input  logic [PRODUCT_PER_STAGE-1:0] operand_B_i,
    input  logic [DATA_WIDTH-2:0]        last_partial_prod_i,
    input  logic                         carry_i,
    output logic [DATA_WIDTH-2:0]        partial_product_o,
    output logic                         carry_o,
    output logic [PRODUCT_PER_STAGE-1:0] final_result_bits_o
);
    localparam int SW = DATA_WIDTH + PRODUCT_PER_STAGE;

    // Worst case (2^DW-1) + (2^DW-1)(2^P-1) < 2^(DW+P), so SW bits never overflow.
    logic [SW-1:0] row_sum [PRODUCT_PER_STAGE+1];

    assign row_sum[0] = {{PRODUCT_PER_STAGE{1'b0}}, carry_i, last_partial_prod_i};

    generate
        for (genvar gi = 0; gi < PRODUCT_PER_STAGE; gi++) begin : g_row
            logic [SW-1:0] row_term;
            assign row_term       = SW'(operand_A_i & {DATA_WIDTH{operand_B_i[gi]}}) << gi;
            assign row_sum[gi+1]  = row_sum[gi] + row_term;
        end
    endgenerate

    assign final_result_bits_o            = row_sum[PRODUCT_PER_STAGE][PRODUCT_PER_STAGE-1:0];
    assign {carry_o, partial_product_o}   = row_sum[PRODUCT_PER_STAGE][SW-1:PRODUCT_PER_STAGE];
endmodule

// File: tb/tb_array_multiplier_sequencer.sv
// Directed and randomised checks of the iterative multiplier at 8/4, 16/4 and 16/16.
`timescale 1ns/1ps

module tb_array_multiplier_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  op_a = '0, op_b = '0;
    logic        valid_in = 1'b0, ready_in = 1'b1;
    logic        ready_out, valid_out, busy;
    logic [15:0] product;

    logic [15:0] a16 = '0, b16 = '0;
    logic        v16 [2];
    logic        r16 [2];
    logic        rd16 [2];
    logic        vo16 [2];
    logic        busy16 [2];
    logic [31:0] p16 [2];

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    array_multiplier_sequencer #(.DATA_WIDTH(8), .PRODUCT_PER_STAGE(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .operand_A_i(op_a), .operand_B_i(op_b), .valid_i(valid_in),
        .ready_o(ready_out), .product_o(product), .valid_o(valid_out),
        .ready_i(ready_in), .busy_o(busy)
    );

    array_multiplier_sequencer #(.DATA_WIDTH(16), .PRODUCT_PER_STAGE(4)) dut16_4 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(1'b0),
        .operand_A_i(a16), .operand_B_i(b16), .valid_i(v16[0]),
        .ready_o(rd16[0]), .product_o(p16[0]), .valid_o(vo16[0]),
        .ready_i(r16[0]), .busy_o(busy16[0])
    );

    array_multiplier_sequencer #(.DATA_WIDTH(16), .PRODUCT_PER_STAGE(16)) dut16_16 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(1'b0),
        .operand_A_i(a16), .operand_B_i(b16), .valid_i(v16[1]),
        .ready_o(rd16[1]), .product_o(p16[1]), .valid_o(vo16[1]),
        .ready_i(r16[1]), .busy_o(busy16[1])
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          stall;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_out && n < 50) begin
            tick();
            n++;
        end
        check("ready_wait", ready_out, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input int stall);
        int lat = 0;
        wait_ready();
        op_a = a; op_b = b; valid_in = 1'b1; ready_in = (stall == 0);
        tick();
        valid_in = 1'b0; op_a = ~a; op_b = ~b;
        check("busy_after_accept", busy, 1);
        check("ready_low_compute", ready_out, 0);
        while (!valid_out && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 2);
        check("product", product, exp);
        check("busy_in_done", busy, 0);
        check("ready_low_done", ready_out, 0);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", valid_out, 1);
            check("stall_product", product, exp);
            check("stall_ready", ready_out, 0);
            tick();
        end
        ready_in = 1'b1;
        tick();
        check("valid_pulse_end", valid_out, 0);
        check("ready_after_handshake", ready_out, 1);
        $display("[TB] op %0d * %0d -> %0d (latency %0d, stall %0d)", a, b, exp, lat, stall);
    endtask

    task automatic run16(input int sel, input logic [15:0] a, input logic [15:0] b, input int exp_lat);
        int          n = 0;
        int          lat = 0;
        logic [31:0] exp;
        exp = {16'd0, a} * {16'd0, b};
        while (!rd16[sel] && n < 50) begin
            tick();
            n++;
        end
        check("w16_ready_wait", rd16[sel], 1);
        a16 = a; b16 = b; v16[sel] = 1'b1; r16[sel] = 1'($urandom_range(0, 1));
        tick();
        v16[sel] = 1'b0; a16 = $urandom(); b16 = $urandom();
        while (!vo16[sel] && lat < 40) begin
            tick();
            lat++;
        end
        check("w16_latency", lat, exp_lat);
        check("w16_product", p16[sel], exp);
        if (!r16[sel]) begin
            repeat ($urandom_range(1, 3)) tick();
            check("w16_stall_product", p16[sel], exp);
            r16[sel] = 1'b1;
        end
        tick();
        $display("[TB] w16 sel=%0d %h * %h -> %h (latency %0d)", sel, a, b, exp, lat);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{8'hFF, 8'hFF, 0, 16'hFE01};
        vecs[1] = '{8'd0,  8'hA5, 0, 16'h0000};
        vecs[2] = '{8'd13, 8'd11, 0, 16'd143};
        vecs[3] = '{8'd200, 8'd3, 5, 16'd600};
        vecs[4] = '{8'h80, 8'h80, 0, 16'h4000};
        vecs[5] = '{8'd1,  8'd1,  1, 16'd1};
        vecs[6] = '{8'hFF, 8'd1,  0, 16'h00FF};
        vecs[7] = '{8'd1,  8'hFF, 2, 16'h00FF};
        vecs[8] = '{8'h12, 8'h34, 0, 16'h03A8};
        vecs[9] = '{8'hF0, 8'h0F, 0, 16'h0E10};

        v16[0] = 1'b0; v16[1] = 1'b0; r16[0] = 1'b1; r16[1] = 1'b1;

        repeat (2) tick();
        check("reset_ready", ready_out, 1);
        check("reset_valid", valid_out, 0);
        check("reset_busy", busy, 0);
        check("reset_product", product, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall);
        end

        // Abort on the first compute cycle: no product may appear.
        op_a = 8'h80; op_b = 8'h80; valid_in = 1'b1;
        tick();
        valid_in = 1'b0; clear = 1'b1;
        check("clear_busy_before", busy, 1);
        tick();
        clear = 1'b0;
        check("clear_ready", ready_out, 1);
        check("clear_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (valid_out) seen++;
            tick();
        end
        check("clear_no_valid", seen, 0);
        $display("[TB] clear during compute, valid pulses seen %0d", seen);

        // clear wins over valid in IDLE.
        op_a = 8'd5; op_b = 8'd5; clear = 1'b1; valid_in = 1'b1;
        tick();
        clear = 1'b0; valid_in = 1'b0;
        check("clear_blocks_accept", busy, 0);
        check("clear_blocks_ready", ready_out, 1);
        run_op(8'd7, 8'd9, 16'd63, 0);

        // Asynchronous reset between edges during COMPUTE.
        op_a = 8'hAB; op_b = 8'hCD; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("areset_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", valid_out, 0);
        check("areset_ready", ready_out, 1);
        check("areset_busy", busy, 0);
        check("areset_product", product, 0);
        tick();
        rst_n = 1'b1;
        lat = 0;
        tick();
        check("areset_no_valid", valid_out, 0);
        $display("[TB] async reset mid-compute");
        run_op(8'd25, 8'd10, 16'd250, 0);

        run16(0, 16'hFFFF, 16'hFFFF, 4);
        run16(1, 16'hFFFF, 16'hFFFF, 1);
        for (int sel = 0; sel < 2; sel++) begin
            for (int k = 0; k < 1000; k++) begin
                run16(sel, 16'($urandom()), 16'($urandom()), (sel == 0) ? 4 : 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
